cpu_clk_ctrl: RTL and testbench

//  Run-control clock-enable scheduler for the CPU core. It replaces the free-running

---
 rtl/cpu_clk_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// Run-control clock-enable scheduler: turns IDLE/RUN/STEP/HALTED requests into
// single-cycle cpu_en pulses on the system clock, with a selectable tick rate.
module cpu_clk_ctrl #(
  parameter int unsigned DIV0 = 100_000_000,
  parameter int unsigned DIV1 = 10_000_000,
  parameter int unsigned DIV2 = 1_000_000,
  parameter int unsigned DIV3 = 1,
  parameter int unsigned CW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_req,
  input  logic          step_req,
  input  logic          stop_req,
  input  logic          halt,
  input  logic [1:0]    rate_sel,
  input  logic          rate_load,
  output logic          cpu_en,
  output logic [1:0]    state,
  output logic          rate_ack,
  output logic [CW-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  function automatic logic [CW-1:0] div_of(input logic [1:0] sel);
    logic [CW-1:0] d;
    case (sel)
      2'd0:    d = CW'(DIV0);
      2'd1:    d = CW'(DIV1);
      2'd2:    d = CW'(DIV2);
      2'd3:    d = CW'(DIV3);
      default: d = CW'(DIV0);
    endcase
    return d;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_cur_q, div_cur_d;
  logic          pend_v_q, pend_v_d;
  logic [1:0]    pend_sel_q, pend_sel_d;
  logic          cpu_en_q, cpu_en_d;
  logic          rate_ack_q, rate_ack_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          term_s;
  logic          apply_s;

  assign term_s = (cnt_q == (div_cur_q - ONE));

  // Next-state: run control, prescaler, pending-rate application and tick counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_v_d   = pend_v_q;
    pend_sel_d = pend_sel_q;
    cpu_en_d   = 1'b0;
    rate_ack_d = 1'b0;
    tick_d     = tick_q;
    apply_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        apply_s = pend_v_q;
        if (run_req) begin
          state_d = ST_RUN;
          cnt_d   = ZERO;
        end else if (step_req && !halt) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        apply_s = pend_v_q;
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          cnt_d   = ZERO;
        end else if (halt) begin
          state_d = ST_HALTED;
          cnt_d   = ZERO;
        end else if (term_s) begin
          // A pending rate takes effect only once the current period has completed.
          cnt_d    = ZERO;
          cpu_en_d = 1'b1;
          apply_s  = pend_v_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HALTED: begin
        apply_s = pend_v_q;
        if (stop_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO;
      end
    endcase

    if (apply_s) begin
      div_cur_d  = div_of(pend_sel_q);
      rate_ack_d = 1'b1;
      pend_v_d   = 1'b0;
    end else begin
      div_cur_d  = div_cur_q;
    end

    // A load on the applying edge survives as the next pending value.
    if (rate_load) begin
      pend_v_d   = 1'b1;
      pend_sel_d = rate_sel;
    end else begin
      pend_sel_d = pend_sel_q;
    end

    if (cpu_en_d) begin
      tick_d = tick_q + ONE;
    end else begin
      tick_d = tick_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= ZERO;
      div_cur_q  <= CW'(DIV0);
      pend_v_q   <= 1'b0;
      pend_sel_q <= 2'b00;
      cpu_en_q   <= 1'b0;
      rate_ack_q <= 1'b0;
      tick_q     <= ZERO;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_v_q   <= pend_v_d;
      pend_sel_q <= pend_sel_d;
      cpu_en_q   <= cpu_en_d;
      rate_ack_q <= rate_ack_d;
      tick_q     <= tick_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign state    = state_q;
  assign rate_ack = rate_ack_q;
  assign tick_cnt = tick_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: vector table plus hand-written corner sequences.
// A second instance with a 4-bit counter exercises the tick_cnt wrap.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_req = 1'b0, step_req = 1'b0, stop_req = 1'b0, halt = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic        rate_load = 1'b0;

  logic        en_a, ack_a, en_b, ack_b;
  logic [1:0]  st_a, st_b;
  logic [31:0] tick_a;
  logic [3:0]  tick_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DIV0(4), .DIV1(1), .DIV2(7), .DIV3(2), .CW(32)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .halt(halt), .rate_sel(rate_sel), .rate_load(rate_load),
    .cpu_en(en_a), .state(st_a), .rate_ack(ack_a), .tick_cnt(tick_a)
  );

  cpu_clk_ctrl #(.DIV0(4), .DIV1(1), .DIV2(7), .DIV3(2), .CW(4)) dut_small (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .halt(halt), .rate_sel(rate_sel), .rate_load(rate_load),
    .cpu_en(en_b), .state(st_b), .rate_ack(ack_b), .tick_cnt(tick_b)
  );

  typedef struct {
    logic        run, step, stop, hlt;
    logic [1:0]  sel;
    logic        load;
    logic        en;
    logic [1:0]  st;
    logic        ack;
    logic [31:0] tick;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, s, p, h, input logic [1:0] sl, input logic ld,
                     input logic e, input logic [1:0] st, input logic a, input int t);
    vec_t v;
    v.run = r; v.step = s; v.stop = p; v.hlt = h; v.sel = sl; v.load = ld;
    v.en = e; v.st = st; v.ack = a; v.tick = 32'(t);
    vt.push_back(v);
  endtask

  task automatic drv(input logic r, s, p, h, input logic [1:0] sl, input logic ld);
    run_req = r; step_req = s; stop_req = p; halt = h; rate_sel = sl; rate_load = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0; halt = 1'b0;
    rate_sel = 2'd0; rate_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // run r, step s, stop p, halt h, sel, load | en, state, ack, tick
    add(1,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0,0, 0,1,0,1);
    add(0,0,0,0,0,0, 1,1,0,2);
    add(0,0,0,0,0,0, 0,1,0,2);
    add(0,0,0,0,0,0, 0,1,0,2);
    add(0,0,0,0,0,0, 0,1,0,2);
    add(0,0,0,0,0,0, 1,1,0,3);
    add(0,0,1,0,0,0, 0,0,0,3);
    add(0,1,0,0,0,0, 1,2,0,4);
    add(0,0,0,0,0,0, 0,0,0,4);
    add(1,0,0,0,0,0, 0,1,0,4);
    add(0,1,0,0,0,0, 0,1,0,4);
    add(0,1,0,0,0,0, 0,1,0,4);
    add(0,0,0,0,0,0, 0,1,0,4);
    add(0,0,0,0,0,0, 1,1,0,5);
    add(0,1,0,0,0,0, 0,1,0,5);
    add(0,0,1,0,0,0, 0,0,0,5);
    add(0,1,0,1,0,0, 0,0,0,5);
    add(1,1,0,0,0,0, 0,1,0,5);
    add(0,0,1,0,0,0, 0,0,0,5);
    add(0,0,0,0,3,1, 0,0,0,5);
    add(0,0,0,0,0,0, 0,0,1,5);
    add(0,0,0,0,0,0, 0,0,0,5);
    add(1,0,0,0,0,0, 0,1,0,5);
    add(0,0,0,0,0,0, 0,1,0,5);
    add(0,0,0,0,0,0, 1,1,0,6);
    add(0,0,0,0,0,0, 0,1,0,6);
    add(0,0,0,0,0,0, 1,1,0,7);
    add(0,0,1,0,0,0, 0,0,0,7);
    add(0,0,0,0,0,1, 0,0,0,7);
    add(0,0,0,0,0,0, 0,0,1,7);
    add(0,0,0,0,0,0, 0,0,0,7);
    add(0,1,0,0,0,0, 1,2,0,8);
    add(1,0,0,0,0,0, 0,0,0,8);
    add(0,0,0,0,0,0, 0,0,0,8);

    #2;
    chk("reset en", 32'(en_a), 32'd0);
    chk("reset state", 32'(st_a), 32'd0);
    chk("reset ack", 32'(ack_a), 32'd0);
    chk("reset tick", tick_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      drv(vt[i].run, vt[i].step, vt[i].stop, vt[i].hlt, vt[i].sel, vt[i].load);
      chk($sformatf("vec%0d en", i), 32'(en_a), 32'(vt[i].en));
      chk($sformatf("vec%0d state", i), 32'(st_a), 32'(vt[i].st));
      chk($sformatf("vec%0d ack", i), 32'(ack_a), 32'(vt[i].ack));
      chk($sformatf("vec%0d tick", i), tick_a, vt[i].tick);
    end

    // Rate change mid-RUN: old period completes, then 7-cycle, then full speed.
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle_cyc();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
    chk("rate E2 en", 32'(en_a), 32'd0);
    idle_cyc();
    chk("rate E3 en", 32'(en_a), 32'd0);
    idle_cyc();
    chk("rate E4 en", 32'(en_a), 32'd1);
    chk("rate E4 ack", 32'(ack_a), 32'd1);
    chk("rate E4 tick", tick_a, 32'd1);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 7; j++) begin
        idle_cyc();
        chk($sformatf("div7 p%0d c%0d en", k, j), 32'(en_a), (j == 6) ? 32'd1 : 32'd0);
        chk($sformatf("div7 p%0d c%0d ack", k, j), 32'(ack_a), 32'd0);
      end
      chk($sformatf("div7 p%0d tick", k), tick_a, 32'(2 + k));
    end
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    chk("sel1 load en", 32'(en_a), 32'd0);
    for (int j = 0; j < 5; j++) begin
      idle_cyc();
      chk($sformatf("sel1 wait%0d en", j), 32'(en_a), 32'd0);
    end
    idle_cyc();
    chk("sel1 apply en", 32'(en_a), 32'd1);
    chk("sel1 apply ack", 32'(ack_a), 32'd1);
    chk("sel1 apply tick", tick_a, 32'd4);
    for (int j = 0; j < 3; j++) begin
      idle_cyc();
      chk($sformatf("full speed%0d en", j), 32'(en_a), 32'd1);
      chk($sformatf("full speed%0d ack", j), 32'(ack_a), 32'd0);
      chk($sformatf("full speed%0d tick", j), tick_a, 32'(5 + j));
    end
    drv(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("full speed stop state", 32'(st_a), 32'd0);

    // Halt arriving on the terminal-count edge suppresses the pulse.
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int j = 0; j < 3; j++) idle_cyc();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("halt en", 32'(en_a), 32'd0);
    chk("halt state", 32'(st_a), 32'd3);
    chk("halt tick", tick_a, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("halted run state", 32'(st_a), 32'd3);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("halted step state", 32'(st_a), 32'd3);
    chk("halted step en", 32'(en_a), 32'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("halted stop state", 32'(st_a), 32'd0);

    // Stop coincident with the terminal count, then a fresh run.
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int j = 0; j < 3; j++) idle_cyc();
    drv(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("stop tc en", 32'(en_a), 32'd0);
    chk("stop tc state", 32'(st_a), 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      idle_cyc();
      chk($sformatf("rerun c%0d en", j), 32'(en_a), 32'd0);
    end
    idle_cyc();
    chk("rerun pulse en", 32'(en_a), 32'd1);
    chk("rerun pulse tick", tick_a, 32'd1);

    // Asynchronous reset mid-pulse at full speed, then rate back to DIV0.
    do_reset();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    idle_cyc();
    chk("idle load ack", 32'(ack_a), 32'd1);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle_cyc();
    idle_cyc();
    chk("pre-rst en", 32'(en_a), 32'd1);
    chk("pre-rst tick", tick_a, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst en", 32'(en_a), 32'd0);
    chk("async rst state", 32'(st_a), 32'd0);
    chk("async rst tick", tick_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      idle_cyc();
      chk($sformatf("post-rst c%0d en", j), 32'(en_a), 32'd0);
    end
    idle_cyc();
    chk("post-rst pulse en", 32'(en_a), 32'd1);

    // tick_cnt wrap on the 4-bit instance.
    do_reset();
    for (int j = 0; j < 15; j++) begin
      drv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      idle_cyc();
    end
    chk("wrap pre tick", 32'(tick_b), 32'd15);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("wrap en", 32'(en_b), 32'd1);
    chk("wrap tick", 32'(tick_b), 32'd0);
    chk("wrap wide tick", tick_a, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
